// File: rtl/overlay_prefetch.sv
// rtl/overlay_prefetch.sv - overlay pixel prefetch FIFO between sdram read port and blend stage
module overlay_prefetch #(
  parameter int          ADDR_W    = 25,
  parameter int          DEPTH     = 16,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic                   ce_pix,
  input  logic                   hblank,
  input  logic                   vblank,
  output logic                   mem_req,
  output logic [ADDR_W-1:0]      mem_addr,
  input  logic                   mem_valid,
  input  logic [15:0]            mem_data,
  output logic [3:0]             bg_r,
  output logic [3:0]             bg_g,
  output logic [3:0]             bg_b,
  output logic [3:0]             bg_a,
  output logic [$clog2(DEPTH):0] level,
  output logic                   underflow
);

  localparam int                PW       = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [PW:0]       FULL_LVL = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

  state_t        state, state_nx;
  logic          vb_ce;
  logic          inflight;
  logic          discard;
  logic [15:0]   fifo_mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [15:0]   pix;

  // vblank is only sampled on pixel enables, so both edges are seen in pixel time
  logic fs, vb_fall, flush, full, empty, rsp, push, pop, pop_ok;
  assign fs      = ce_pix & vblank & ~vb_ce;
  assign vb_fall = ce_pix & ~vblank & vb_ce;
  assign flush   = ~enable | fs;
  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  assign rsp     = mem_valid & inflight;
  assign push    = rsp & ~discard & ~flush;
  assign pop     = enable & (state == RUN) & ce_pix & ~(hblank | vblank);
  assign pop_ok  = pop & ~empty;

  assign bg_a = pix[15:12];
  assign bg_b = pix[11:8];
  assign bg_g = pix[7:4];
  assign bg_r = pix[3:0];

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // next state and request strobe; a request is only raised with the slot free and room left
  always_comb begin
    state_nx = state;
    mem_req  = 1'b0;
    case (state)
      IDLE:    if (fs) state_nx = FILL;
      FILL:    if (!fs && (full || vb_fall)) state_nx = RUN;
      RUN:     if (fs) state_nx = FILL;
      default: state_nx = IDLE;
    endcase
    if (!enable) state_nx = IDLE;
    if (enable && state != IDLE && !fs && !inflight && !full) mem_req = 1'b1;
  end

  // frame-start detect, fetch address, in-flight slot and discard mark
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vb_ce    <= 1'b0;
      mem_addr <= BASE;
      inflight <= 1'b0;
      discard  <= 1'b0;
    end else begin
      if (ce_pix) vb_ce <= vblank;
      if (flush)        mem_addr <= BASE;
      else if (mem_req) mem_addr <= mem_addr + ADDR_W'(2);
      if (mem_req)  inflight <= 1'b1;
      else if (rsp) inflight <= 1'b0;
      // a response landing in the flush cycle is consumed here; later ones get marked
      if (rsp)                   discard <= 1'b0;
      else if (flush && inflight) discard <= 1'b1;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok) rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop_ok)      level <= level + (PW+1)'(1);
      else if (!push && pop_ok) level <= level - (PW+1)'(1);
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= mem_data;
  end

  // output pixel and sticky underflow; outside RUN the overlay is transparent black
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix       <= '0;
      underflow <= 1'b0;
    end else begin
      if (state_nx != RUN) pix <= '0;
      else if (pop)        pix <= empty ? 16'h0000 : fifo_mem[rd_ptr];
      if (fs)                 underflow <= 1'b0;
      else if (pop && empty)  underflow <= 1'b1;
    end
  end

endmodule
